// File: rtl/score_digits_pkg.sv
// Shared types and helpers for the score digit driver.
package score_digits_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PENDING = 2'd2
  } state_t;

  typedef logic [3:0] nibble_t;

  localparam int BCD_DIGITS = 4;
  typedef nibble_t [BCD_DIGITS-1:0] bcd_t;

  // Largest value representable with n decimal digits.
  function automatic int unsigned MAX_DECIMAL(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one input bit per cycle after start, done marks the final step.
module bin2bcd_seq
  import score_digits_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [VALUE_W-1:0]         value,
  output logic                       done,
  output nibble_t [NUM_DIGITS-1:0]   bcd
);
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0]       shift_q, shift_d;
  nibble_t [NUM_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
  end

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    if (start) begin
      shift_d = value;
      bcd_d   = '0;
      cnt_d   = CNT_W'(VALUE_W);
    end else if (cnt_q != '0) begin
      {bcd_d, shift_d} = {adj, shift_q} << 1;
      cnt_d            = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_digits_driver.sv
// Score-to-glyph driver: BCD conversion, frame-synchronous display update, pixel mapping.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module score_digits_driver
  import score_digits_pkg::*;
#(
  parameter int          NUM_DIGITS  = 4,
  parameter int          VALUE_W     = 14,
  parameter int          DIGIT_W     = 16,
  parameter int          DIGIT_H     = 32,
  parameter int          DIGIT_PITCH = 32,
  parameter logic [10:0] TOP_LEFT_X  = 11'd20,
  parameter logic [10:0] TOP_LEFT_Y  = 11'd20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               startOfFrame,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic               overflow,
  output logic               InsideRectangle,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic [7:0]         digit
);
  localparam int          PITCH_LG = $clog2(DIGIT_PITCH);
  localparam logic [10:0] SPAN     = 11'(NUM_DIGITS * DIGIT_PITCH);

  state_t                   state_q, state_d;
  logic                     ovf_q, ovf_d;
  nibble_t [NUM_DIGITS-1:0] disp_q, disp_d;
  nibble_t [NUM_DIGITS-1:0] result;
  logic                     conv_start, conv_done;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (value),
    .done  (conv_done),
    .bcd   (result)
  );

  always_comb begin
    state_d    = state_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    conv_start = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        conv_start = 1'b1;
        ovf_d      = 32'(value) > MAX_DECIMAL(NUM_DIGITS);
        state_d    = CONVERT;
      end
      CONVERT: if (conv_done) state_d = PENDING;
      PENDING: if (startOfFrame) begin
        for (int i = 0; i < NUM_DIGITS; i++) disp_d[i] = ovf_q ? 4'd9 : result[i];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

  logic [10:0] rel_x, rel_y, idx, col;
  logic        valid, ins_d;
  nibble_t     sel;
  logic [10:0] ox_d, oy_d;
  logic [7:0]  dig_d;

  always_comb begin
    rel_x = pixelX - TOP_LEFT_X;
    rel_y = pixelY - TOP_LEFT_Y;
    valid = (pixelX >= TOP_LEFT_X) && (pixelY >= TOP_LEFT_Y) &&
            (rel_y < 11'(DIGIT_H)) && (rel_x < SPAN);
    idx   = rel_x >> PITCH_LG;
    col   = rel_x & 11'(DIGIT_PITCH - 1);
  end

  // Display is stored LSD at index 0; screen index 0 is the leftmost (MSD).
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == 11'(i)) sel = disp_q[NUM_DIGITS-1-i];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic blank, lz;
  always_comb begin
    blank = 1'b0;
    lz    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lz = lz && (disp_q[NUM_DIGITS-1-i] == 4'd0);
      if (idx == 11'(i)) blank = lz && (i != NUM_DIGITS - 1);
    end
  end
  assign ins_d = valid && (col < 11'(DIGIT_W)) && !blank;
`else
  assign ins_d = valid && (col < 11'(DIGIT_W));
`endif

  always_comb begin
    ox_d  = ins_d ? col : '0;
    oy_d  = ins_d ? rel_y : '0;
    dig_d = ins_d ? {4'b0, sel} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      ovf_q           <= 1'b0;
      disp_q          <= '0;
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
      digit           <= '0;
    end else begin
      state_q         <= state_d;
      ovf_q           <= ovf_d;
      disp_q          <= disp_d;
      InsideRectangle <= ins_d;
      offsetX         <= ox_d;
      offsetY         <= oy_d;
      digit           <= dig_d;
    end
  end

endmodule
